// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: skid FSM state encoding and MEM/WB payload layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    localparam int W_DM    = 32;
    localparam int W_ALU   = 32;
    localparam int W_PC    = 30;
    localparam int W_WBSEL = 2;
    localparam int W_RW    = 5;
    localparam int W_INSTR = 32;

    // Field offsets inside the packed MEM/WB data word, Instr at the LSBs
    localparam int OFF_INSTR = 0;
    localparam int OFF_RW    = OFF_INSTR + W_INSTR;
    localparam int OFF_WBSEL = OFF_RW + W_RW;
    localparam int OFF_PC    = OFF_WBSEL + W_WBSEL;
    localparam int OFF_ALU   = OFF_PC + W_PC;
    localparam int OFF_DM    = OFF_ALU + W_ALU;
    localparam int W_MEMWB   = OFF_DM + W_DM;

    typedef struct packed {
        logic [W_DM-1:0]    dm_result;
        logic [W_ALU-1:0]   alu_out;
        logic [W_PC-1:0]    pc_add_one;
        logic [W_WBSEL-1:0] wb_sel;
        logic [W_RW-1:0]    rw;
        logic [W_INSTR-1:0] instr;
    } memwb_t;

    function automatic logic [W_MEMWB-1:0] pack_memwb(input memwb_t fields);
        return fields;
    endfunction

    function automatic memwb_t unpack_memwb(input logic [W_MEMWB-1:0] word);
        return memwb_t'(word);
    endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached, cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count register with saturation at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1'b1);
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, flush,
// optional 2-entry skid buffer and a saturating downstream-stall counter.
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = W_MEMWB,
    parameter int CTRL_W = 1,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              accept_s;
    logic              consume_s;
    logic              in_ready_s;
    logic              m_valid_r;
    logic [DATA_W-1:0] m_data_r;
    logic [CTRL_W-1:0] m_ctrl_r;

    assign accept_s  = in_valid & in_ready_s;
    assign consume_s = m_valid_r & out_ready;

    if (SKID != 0) begin : g_skid
        state_e            state_r;
        state_e            state_nxt_s;
        logic              in_ready_r;
        logic [DATA_W-1:0] s_data_r;
        logic [CTRL_W-1:0] s_ctrl_r;
        logic              m_load_in_s;
        logic              m_load_skid_s;
        logic              m_clr_s;
        logic              s_load_s;
        logic              s_clr_s;

        // State register; in_ready and out_valid are registered decodes of the next state
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r    <= ST_EMPTY;
                in_ready_r <= 1'b1;
                m_valid_r  <= 1'b0;
            end else begin
                state_r    <= state_nxt_s;
                in_ready_r <= (state_nxt_s != ST_SKID);
                m_valid_r  <= (state_nxt_s != ST_EMPTY);
            end
        end

        // Next-state logic, flush overrides every transition
        always_comb begin
            state_nxt_s = state_r;
            if (flush) begin
                state_nxt_s = ST_EMPTY;
            end else begin
                case (state_r)
                    ST_EMPTY: begin
                        if (accept_s) state_nxt_s = ST_FULL;
                        else          state_nxt_s = ST_EMPTY;
                    end
                    ST_FULL: begin
                        if (accept_s && !consume_s)      state_nxt_s = ST_SKID;
                        else if (!accept_s && consume_s) state_nxt_s = ST_EMPTY;
                        else                             state_nxt_s = ST_FULL;
                    end
                    ST_SKID: begin
                        if (consume_s) state_nxt_s = ST_FULL;
                        else           state_nxt_s = ST_SKID;
                    end
                    default: state_nxt_s = ST_EMPTY;
                endcase
            end
        end

        // Datapath load/clear strobes derived from the current state
        always_comb begin
            m_load_in_s   = 1'b0;
            m_load_skid_s = 1'b0;
            m_clr_s       = 1'b0;
            s_load_s      = 1'b0;
            s_clr_s       = 1'b0;
            if (flush) begin
                m_clr_s = 1'b1;
                s_clr_s = 1'b1;
            end else begin
                case (state_r)
                    ST_EMPTY: begin
                        if (accept_s) m_load_in_s = 1'b1;
                        else          m_clr_s     = 1'b1;
                    end
                    ST_FULL: begin
                        if (accept_s && consume_s) m_load_in_s = 1'b1;
                        else if (consume_s)        m_clr_s     = 1'b1;
                        else if (accept_s)         s_load_s    = 1'b1;
                        else                       m_load_in_s = 1'b0;
                    end
                    ST_SKID: begin
                        if (consume_s) begin
                            m_load_skid_s = 1'b1;
                            s_clr_s       = 1'b1;
                        end else begin
                            m_load_skid_s = 1'b0;
                        end
                    end
                    default: begin
                        m_clr_s = 1'b1;
                        s_clr_s = 1'b1;
                    end
                endcase
            end
        end

        // Main and skid payload registers; ctrl bits are zeroed whenever a slot empties
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_data_r <= {DATA_W{1'b0}};
                m_ctrl_r <= {CTRL_W{1'b0}};
                s_data_r <= {DATA_W{1'b0}};
                s_ctrl_r <= {CTRL_W{1'b0}};
            end else begin
                if (m_load_in_s) begin
                    m_data_r <= in_data;
                    m_ctrl_r <= in_ctrl;
                end else if (m_load_skid_s) begin
                    m_data_r <= s_data_r;
                    m_ctrl_r <= s_ctrl_r;
                end else if (m_clr_s) begin
                    m_ctrl_r <= {CTRL_W{1'b0}};
                end
                if (s_load_s) begin
                    s_data_r <= in_data;
                    s_ctrl_r <= in_ctrl;
                end else if (s_clr_s) begin
                    s_data_r <= {DATA_W{1'b0}};
                    s_ctrl_r <= {CTRL_W{1'b0}};
                end
            end
        end

        assign in_ready_s = in_ready_r;
    end else begin : g_single
        assign in_ready_s = out_ready | ~m_valid_r;

        // Single register stage; flush and drain leave a zero-ctrl bubble
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_valid_r <= 1'b0;
                m_data_r  <= {DATA_W{1'b0}};
                m_ctrl_r  <= {CTRL_W{1'b0}};
            end else if (flush) begin
                m_valid_r <= 1'b0;
                m_ctrl_r  <= {CTRL_W{1'b0}};
            end else if (accept_s) begin
                m_valid_r <= 1'b1;
                m_data_r  <= in_data;
                m_ctrl_r  <= in_ctrl;
            end else if (consume_s) begin
                m_valid_r <= 1'b0;
                m_ctrl_r  <= {CTRL_W{1'b0}};
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (m_valid_r & ~out_ready),
        .count (stall_cnt)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = m_valid_r;
    assign out_data  = m_data_r;
    assign out_ctrl  = m_ctrl_r;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: one SKID=1 and one SKID=0 instance, driven one at a time.
module tb_pipe_stage_skid_reg;

    localparam int DW = 133;
    localparam int CW = 1;
    localparam int NW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          sel;

    logic          in_valid1, in_valid0;
    logic          ir1, ir0, ov1, ov0;
    logic [DW-1:0] od1, od0;
    logic [CW-1:0] oc1, oc0;
    logic [NW-1:0] cnt1, cnt0;

    logic          cur_ir, cur_ov;
    logic [DW-1:0] cur_od;
    logic [CW-1:0] cur_oc;
    logic [NW-1:0] cur_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DW+CW-1:0] q1[$];
    logic [DW+CW-1:0] q0[$];

    assign in_valid1 = in_valid & sel;
    assign in_valid0 = in_valid & ~sel;
    assign cur_ir  = sel ? ir1  : ir0;
    assign cur_ov  = sel ? ov1  : ov0;
    assign cur_od  = sel ? od1  : od0;
    assign cur_oc  = sel ? oc1  : oc0;
    assign cur_cnt = sel ? cnt1 : cnt0;

    pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_skid1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid1), .in_ready(ir1), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1),
        .stall_cnt(cnt1)
    );

    pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_skid0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid0), .in_ready(ir0), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0),
        .stall_cnt(cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s sel=%0d actual=%0h required=%0h", nm, sel, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Monitors sample mid-cycle: pop on the coming consume, push on the coming accept
    always @(negedge clk) begin : mon1
        logic [DW+CW-1:0] e;
        if (!rst_n) begin
            q1.delete();
        end else begin
            if (!ov1) chk("bubble_ctrl1", 256'(oc1), 256'(0));
            if (ov1 && out_ready) begin
                if (q1.size() == 0) chk("sb1_unexpected", 256'({od1, oc1}), 256'(0) - 256'(1));
                else begin
                    e = q1.pop_front();
                    chk("sb1_payload", 256'({od1, oc1}), 256'(e));
                end
            end
            if (flush) q1.delete();
            else if (in_valid1 && ir1) q1.push_back({in_data, in_ctrl});
        end
    end

    always @(negedge clk) begin : mon0
        logic [DW+CW-1:0] e;
        if (!rst_n) begin
            q0.delete();
        end else begin
            if (!ov0) chk("bubble_ctrl0", 256'(oc0), 256'(0));
            if (ov0 && out_ready) begin
                if (q0.size() == 0) chk("sb0_unexpected", 256'({od0, oc0}), 256'(0) - 256'(1));
                else begin
                    e = q0.pop_front();
                    chk("sb0_payload", 256'({od0, oc0}), 256'(e));
                end
            end
            if (flush) q0.delete();
            else if (in_valid0 && ir0) q0.push_back({in_data, in_ctrl});
        end
    end

    task automatic test_stream();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, DW'(k), 1'b1);
            step();
            chk("stream_data", 256'(cur_od), 256'(k));
            chk("stream_valid", 256'(cur_ov), 256'(1));
        end
        drive(1'b0, DW'(0), 1'b0);
        step();
        chk("stream_drained", 256'(cur_ov), 256'(0));
        chk("stream_stall", 256'(cur_cnt), 256'(0));
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        drive(1'b1, DW'('hA), 1'b1);
        step();
        chk("bp_a_lands", 256'(cur_od), 256'('hA));
        out_ready = 1'b0;
        drive(1'b1, DW'('hB), 1'b1);
        step();
        chk("bp_ready_low", 256'(cur_ir), 256'(0));
        chk("bp_stall1", 256'(cur_cnt), 256'(1));
        if (sel) drive(1'b1, DW'('hC), 1'b1);
        step();
        step();
        chk("bp_hold_a", 256'(cur_od), 256'('hA));
        chk("bp_stall3", 256'(cur_cnt), 256'(3));
        out_ready = 1'b1;
        #1;
        chk("bp_ready_path", 256'(cur_ir), sel ? 256'(0) : 256'(1));
        step();
        chk("bp_out_b", 256'(cur_od), 256'('hB));
        chk("bp_ready_back", 256'(cur_ir), 256'(1));
        drive(1'b1, DW'('hC), 1'b1);
        step();
        chk("bp_out_c", 256'(cur_od), 256'('hC));
        drive(1'b0, DW'(0), 1'b0);
        step();
        chk("bp_drained", 256'(cur_ov), 256'(0));
        chk("bp_stall_final", 256'(cur_cnt), 256'(3));
        chk("bp_sb_empty", 256'(sel ? q1.size() : q0.size()), 256'(0));
    endtask

    initial begin
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0; sel = 1'b1;
        do_reset();

        chk("rst_ov1", 256'(ov1), 256'(0));
        chk("rst_oc1", 256'(oc1), 256'(0));
        chk("rst_od1", 256'(od1), 256'(0));
        chk("rst_cnt1", 256'(cnt1), 256'(0));
        chk("rst_ir1", 256'(ir1), 256'(1));
        chk("rst_ov0", 256'(ov0), 256'(0));
        chk("rst_cnt0", 256'(cnt0), 256'(0));

        // Tests 1-2 on SKID=1
        test_stream();
        test_backpressure();

        // Test 3: flush in SKID state with a valid ctrl=1 entry on the input
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, DW'('h11), 1'b1);
        step();
        drive(1'b1, DW'('h22), 1'b1);
        step();
        chk("fl_in_skid", 256'(cur_ir), 256'(0));
        drive(1'b1, DW'('h33), 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, DW'(0), 1'b0);
        chk("fl_ov", 256'(cur_ov), 256'(0));
        chk("fl_oc", 256'(cur_oc), 256'(0));
        chk("fl_ir", 256'(cur_ir), 256'(1));
        chk("fl_cnt_kept", 256'(cur_cnt), 256'(2));
        out_ready = 1'b1;
        step();
        chk("fl_skid_gone", 256'(cur_ov), 256'(0));
        // Flush while a handshake completes: that entry is dropped too
        out_ready = 1'b0;
        drive(1'b1, DW'('h44), 1'b1);
        step();
        drive(1'b1, DW'('h66), 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, DW'(0), 1'b1);
        chk("fl2_ov", 256'(cur_ov), 256'(0));
        out_ready = 1'b1;
        step();
        chk("fl2_dropped", 256'(cur_ov), 256'(0));

        // Test 4: bubbles never carry ctrl
        drive(1'b0, DW'('h5), 1'b1);
        step();
        chk("bub_ov", 256'(cur_ov), 256'(0));
        chk("bub_oc", 256'(cur_oc), 256'(0));
        drive(1'b1, DW'('h77), 1'b1);
        step();
        chk("bub_live_oc", 256'(cur_oc), 256'(1));
        drive(1'b0, DW'('h78), 1'b1);
        step();
        chk("bub_after_oc", 256'(cur_oc), 256'(0));

        // Test 5: 4-bit stall counter saturates at 15
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, DW'('h55), 1'b1);
        step();
        drive(1'b0, DW'(0), 1'b0);
        repeat (14) step();
        chk("sat_14", 256'(cur_cnt), 256'(14));
        step();
        chk("sat_15", 256'(cur_cnt), 256'(15));
        repeat (5) step();
        chk("sat_hold", 256'(cur_cnt), 256'(15));
        out_ready = 1'b1;
        step();

        // Test 6: async reset between edges mid-stream
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, DW'(k + 'h90), 1'b1);
            step();
        end
        chk("ar_pre_ov", 256'(cur_ov), 256'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("ar_ov", 256'(cur_ov), 256'(0));
        chk("ar_od", 256'(cur_od), 256'(0));
        chk("ar_oc", 256'(cur_oc), 256'(0));
        chk("ar_cnt", 256'(cur_cnt), 256'(0));
        chk("ar_ir", 256'(cur_ir), 256'(1));
        drive(1'b0, DW'(0), 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // Rerun tests 1-2 on SKID=0
        sel = 1'b0;
        do_reset();
        test_stream();
        test_backpressure();

        step();
        chk("end_sb1_empty", 256'(q1.size()), 256'(0));
        chk("end_sb0_empty", 256'(q0.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
